// File: rtl/bp_fe_ras_pkg.sv
// Shared front-end types for the return address stack: checkpoint struct
// declaration macro and the per-cycle stack operation encoding.
`define BP_FE_RAS_CKPT_DECLARE_S(cnt_width_mp, ptr_width_mp) \
    typedef struct packed { \
        logic [(cnt_width_mp)-1:0] cnt; \
        logic [(ptr_width_mp)-1:0] tos; \
    } bp_fe_ras_ckpt_s

package bp_fe_pkg;

    localparam int unsigned ras_els_default_lp = 8;

    // Default-geometry checkpoint, embedded by the branch metadata fwd struct
    `BP_FE_RAS_CKPT_DECLARE_S($clog2(ras_els_default_lp + 1), $clog2(ras_els_default_lp));

    typedef enum logic [2:0] {
        e_ras_idle,
        e_ras_clear,
        e_ras_restore,
        e_ras_push,
        e_ras_pop,
        e_ras_swap
    } bp_fe_ras_op_e;

endpackage

// File: rtl/bp_fe_ras_if.sv
// Request/response bundle between the fetch pipeline and the return address stack.
interface bp_fe_ras_if #(
    parameter int vaddr_width_p = 39,
    parameter int ras_els_p     = 8,
    localparam int ckpt_width_lp = $clog2(ras_els_p) + $clog2(ras_els_p + 1)
);
    logic                     clear;
    logic                     push_v;
    logic [vaddr_width_p-1:0] push_addr;
    logic                     pop_v;
    logic                     restore_v;
    logic [ckpt_width_lp-1:0] restore_ckpt;
    logic                     top_v;
    logic [vaddr_width_p-1:0] top_addr;
    logic [ckpt_width_lp-1:0] ckpt;

    modport master (
        output clear, push_v, push_addr, pop_v, restore_v, restore_ckpt,
        input  top_v, top_addr, ckpt
    );

    modport slave (
        input  clear, push_v, push_addr, pop_v, restore_v, restore_ckpt,
        output top_v, top_addr, ckpt
    );
endinterface

// File: rtl/bp_fe_ras_mem.sv
// Return address storage: one synchronous write port, one asynchronous read port.
module bsg_mem_1r1w #(
    parameter int width_p = 39,
    parameter int els_p   = 8,
    localparam int addr_width_lp = $clog2(els_p)
) (
    input  logic                     w_clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);
    logic [width_p-1:0] r_mem [els_p];

    always_ff @(posedge w_clk_i) begin
        if (w_v_i) r_mem[w_addr_i] <= w_data_i;
    end

    assign r_data_o = r_mem[r_addr_i];
endmodule

// File: rtl/bp_fe_ras.sv
// Return address stack: circular entry buffer with top pointer and saturating
// occupancy count, checkpoint/restore of {count, tos}, and synchronous flush.
module bp_fe_ras
    import bp_fe_pkg::*;
#(
    parameter int vaddr_width_p = 39,
    parameter int ras_els_p     = 8,
    localparam int ptr_width_lp = $clog2(ras_els_p),
    localparam int cnt_width_lp = $clog2(ras_els_p + 1)
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic                                clear_i,
    input  logic                                push_v_i,
    input  logic [vaddr_width_p-1:0]            push_addr_i,
    input  logic                                pop_v_i,
    output logic                                top_v_o,
    output logic [vaddr_width_p-1:0]            top_addr_o,
    output logic [ptr_width_lp+cnt_width_lp-1:0] ckpt_o,
    input  logic                                restore_v_i,
    input  logic [ptr_width_lp+cnt_width_lp-1:0] restore_ckpt_i
);
    `BP_FE_RAS_CKPT_DECLARE_S(cnt_width_lp, ptr_width_lp);

    localparam logic [cnt_width_lp-1:0] max_cnt_lp = cnt_width_lp'(ras_els_p);

    logic [ptr_width_lp-1:0]  r_tos;
    logic [cnt_width_lp-1:0]  r_cnt;
    bp_fe_ras_op_e            w_op;
    bp_fe_ras_ckpt_s          w_restore;
    logic [cnt_width_lp-1:0]  w_restore_cnt;
    logic [ptr_width_lp-1:0]  w_tos_inc;
    logic                     w_mem_we;
    logic [ptr_width_lp-1:0]  w_mem_waddr;
    logic [vaddr_width_p-1:0] w_mem_rdata;

    assign w_tos_inc     = r_tos + ptr_width_lp'(1);
    assign w_restore     = bp_fe_ras_ckpt_s'(restore_ckpt_i);
    assign w_restore_cnt = (w_restore.cnt > max_cnt_lp) ? max_cnt_lp : w_restore.cnt;

    // Priority clear > restore > push/pop; an empty pop is folded into idle
    always_comb begin
        w_op = e_ras_idle;
        if (clear_i)                        w_op = e_ras_clear;
        else if (restore_v_i)               w_op = e_ras_restore;
        else if (push_v_i && pop_v_i)       w_op = e_ras_swap;
        else if (push_v_i)                  w_op = e_ras_push;
        else if (pop_v_i && (r_cnt != '0))  w_op = e_ras_pop;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_tos <= '0;
            r_cnt <= '0;
        end else begin
            case (w_op)
                e_ras_clear: begin
                    r_tos <= '0;
                    r_cnt <= '0;
                end
                e_ras_restore: begin
                    r_tos <= w_restore.tos;
                    r_cnt <= w_restore_cnt;
                end
                e_ras_swap: begin
                    if (r_cnt == '0) r_cnt <= cnt_width_lp'(1);
                end
                e_ras_push: begin
                    r_tos <= w_tos_inc;
                    if (r_cnt != max_cnt_lp) r_cnt <= r_cnt + cnt_width_lp'(1);
                end
                e_ras_pop: begin
                    r_tos <= r_tos - ptr_width_lp'(1);
                    r_cnt <= r_cnt - cnt_width_lp'(1);
                end
                default: ;
            endcase
        end
    end

    // Storage is unreset; writes are simply blocked while reset is held
    assign w_mem_we    = reset_n_i && ((w_op == e_ras_push) || (w_op == e_ras_swap));
    assign w_mem_waddr = (w_op == e_ras_swap) ? r_tos : w_tos_inc;

    bsg_mem_1r1w #(
        .width_p (vaddr_width_p),
        .els_p   (ras_els_p)
    ) u_mem (
        .w_clk_i  (clk_i),
        .w_v_i    (w_mem_we),
        .w_addr_i (w_mem_waddr),
        .w_data_i (push_addr_i),
        .r_addr_i (r_tos),
        .r_data_o (w_mem_rdata)
    );

    assign top_v_o    = (r_cnt != '0);
    assign top_addr_o = top_v_o ? w_mem_rdata : '0;
    assign ckpt_o     = {r_cnt, r_tos};
endmodule

// File: tb/tb_bp_fe_ras.sv
// Self-checking bench for bp_fe_ras: directed scenarios plus randomized traffic
// compared against a circular-buffer reference model.
module tb_bp_fe_ras;
    localparam int VAW = 39;
    localparam int ELS = 8;
    localparam int PW  = 3;
    localparam int CW  = 4;
    localparam int CKW = PW + CW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bp_fe_ras_if #(.vaddr_width_p(VAW), .ras_els_p(ELS)) ras_if ();

    bp_fe_ras #(.vaddr_width_p(VAW), .ras_els_p(ELS)) dut (
        .clk_i          (clk),
        .reset_n_i      (rst_n),
        .clear_i        (ras_if.clear),
        .push_v_i       (ras_if.push_v),
        .push_addr_i    (ras_if.push_addr),
        .pop_v_i        (ras_if.pop_v),
        .top_v_o        (ras_if.top_v),
        .top_addr_o     (ras_if.top_addr),
        .ckpt_o         (ras_if.ckpt),
        .restore_v_i    (ras_if.restore_v),
        .restore_ckpt_i (ras_if.restore_ckpt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference: the stack as a ring of return addresses plus a top index and depth
    logic [VAW-1:0] m_mem [ELS];
    bit             m_known [ELS];
    int             m_tos = 0;
    int             m_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit clr, input bit rv, input logic [CKW-1:0] rck,
                              input bit push, input logic [VAW-1:0] addr, input bit pop);
        int c;
        if (clr) begin
            m_cnt = 0;
            m_tos = 0;
        end else if (rv) begin
            c = int'(rck >> PW);
            m_cnt = (c > ELS) ? ELS : c;
            m_tos = int'(rck) % ELS;
        end else if (push && pop) begin
            m_mem[m_tos]   = addr;
            m_known[m_tos] = 1'b1;
            if (m_cnt == 0) m_cnt = 1;
        end else if (push) begin
            m_tos = (m_tos + 1) % ELS;
            m_mem[m_tos]   = addr;
            m_known[m_tos] = 1'b1;
            m_cnt = (m_cnt + 1 > ELS) ? ELS : m_cnt + 1;
        end else if (pop && m_cnt > 0) begin
            m_tos = (m_tos + ELS - 1) % ELS;
            m_cnt = m_cnt - 1;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".top_v"}, 64'(ras_if.top_v), 64'(m_cnt != 0));
        if (m_cnt == 0)
            check({tag, ".top_addr"}, 64'(ras_if.top_addr), 64'd0);
        else if (m_known[m_tos])
            check({tag, ".top_addr"}, 64'(ras_if.top_addr), 64'(m_mem[m_tos]));
        check({tag, ".ckpt"}, 64'(ras_if.ckpt), 64'(m_cnt * ELS + m_tos));
    endtask

    task automatic cyc(input string tag, input bit clr, input bit rv, input logic [CKW-1:0] rck,
                       input bit push, input logic [VAW-1:0] addr, input bit pop);
        ras_if.clear        = clr;
        ras_if.restore_v    = rv;
        ras_if.restore_ckpt = rck;
        ras_if.push_v       = push;
        ras_if.push_addr    = addr;
        ras_if.pop_v        = pop;
        @(posedge clk);
        model_step(clr, rv, rck, push, addr, pop);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic do_push(input string tag, input logic [VAW-1:0] a);
        cyc(tag, 1'b0, 1'b0, '0, 1'b1, a, 1'b0);
    endtask

    task automatic do_pop(input string tag);
        cyc(tag, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        logic [CKW-1:0] saved;
        logic [63:0]    rnd;
        int             r;
        for (int i = 0; i < ELS; i++) m_known[i] = 1'b0;
        ras_if.clear = 0; ras_if.restore_v = 0; ras_if.restore_ckpt = '0;
        ras_if.push_v = 0; ras_if.push_addr = '0; ras_if.pop_v = 0;

        @(negedge clk);
        check("reset.top_v", 64'(ras_if.top_v), 64'd0);
        check("reset.top_addr", 64'(ras_if.top_addr), 64'd0);
        check("reset.ckpt", 64'(ras_if.ckpt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic LIFO
        do_push("lifo.push", 'h100);
        do_push("lifo.push", 'h200);
        do_push("lifo.push", 'h300);
        check("lifo.top3", 64'(ras_if.top_addr), 64'h300);
        do_pop("lifo.pop");
        check("lifo.top2", 64'(ras_if.top_addr), 64'h200);
        do_pop("lifo.pop");
        check("lifo.top1", 64'(ras_if.top_addr), 64'h100);
        do_pop("lifo.pop");
        check("lifo.empty", 64'(ras_if.top_v), 64'd0);

        // Overflow: oldest entry lost, depth saturates
        for (int i = 1; i <= 9; i++) do_push("ovf.push", VAW'(i * 'h10));
        check("ovf.full_cnt", 64'(ras_if.ckpt >> PW), 64'(ELS));
        for (int i = 9; i >= 2; i--) begin
            check("ovf.top", 64'(ras_if.top_addr), 64'(i * 'h10));
            do_pop("ovf.pop");
        end
        check("ovf.drained", 64'(ras_if.top_v), 64'd0);

        // Underflow
        saved = ras_if.ckpt;
        do_pop("udf.pop");
        do_pop("udf.pop");
        check("udf.unchanged", 64'(ras_if.ckpt), 64'(saved));
        do_push("udf.push", 'h44);
        check("udf.top", 64'(ras_if.top_addr), 64'h44);
        check("udf.cnt", 64'(ras_if.ckpt >> PW), 64'd1);

        // Simultaneous push/pop replaces the top
        cyc("swap.clr", 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        do_push("swap.push", 'hA0);
        cyc("swap.both", 1'b0, 1'b0, '0, 1'b1, 'hB0, 1'b1);
        check("swap.top", 64'(ras_if.top_addr), 64'hB0);
        check("swap.cnt", 64'(ras_if.ckpt >> PW), 64'd1);
        do_pop("swap.pop");
        check("swap.empty", 64'(ras_if.top_v), 64'd0);

        // Checkpoint restore rewinds pointers only; clear beats restore
        cyc("rst.clr", 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        do_push("rst.push", 'h1);
        do_push("rst.push", 'h2);
        saved = ras_if.ckpt;
        check("rst.ckpt", 64'(saved), 64'((2 << PW) | 2));
        do_pop("rst.pop");
        do_push("rst.push", 'h3);
        cyc("rst.restore", 1'b0, 1'b1, saved, 1'b1, 'h77, 1'b0);
        check("rst.ckpt_back", 64'(ras_if.ckpt), 64'((2 << PW) | 2));
        check("rst.top", 64'(ras_if.top_addr), 64'h3);
        cyc("rst.clr_wins", 1'b1, 1'b1, saved, 1'b0, '0, 1'b0);
        check("rst.clr_cnt", 64'(ras_if.ckpt >> PW), 64'd0);
        cyc("rst.sat", 1'b0, 1'b1, CKW'((15 << PW) | 5), 1'b0, '0, 1'b0);
        check("rst.sat_cnt", 64'(ras_if.ckpt >> PW), 64'(ELS));

        // Asynchronous reset between edges
        do_push("arst.push", 'h55);
        ras_if.push_v = 1'b1; ras_if.push_addr = 'h66;
        #2 rst_n = 1'b0;
        #1;
        check("arst.top_v", 64'(ras_if.top_v), 64'd0);
        check("arst.ckpt", 64'(ras_if.ckpt), 64'd0);
        ras_if.pop_v = 1'b1; ras_if.restore_v = 1'b1; ras_if.restore_ckpt = CKW'((3 << PW) | 4);
        @(posedge clk);
        @(negedge clk);
        check("arst.hold_v", 64'(ras_if.top_v), 64'd0);
        check("arst.hold_ckpt", 64'(ras_if.ckpt), 64'd0);
        m_cnt = 0;
        m_tos = 0;
        ras_if.push_v = 0; ras_if.pop_v = 0; ras_if.restore_v = 0;
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            r = int'($urandom_range(0, 99));
            rnd = {$urandom(), $urandom()};
            if (r < 3)
                cyc("rnd", 1'b1, 1'($urandom_range(0, 1)), CKW'($urandom()), 1'b1, rnd[VAW-1:0], 1'b1);
            else if (r < 8)
                cyc("rnd", 1'b0, 1'b1, CKW'($urandom()), 1'($urandom_range(0, 1)), rnd[VAW-1:0],
                    1'($urandom_range(0, 1)));
            else
                cyc("rnd", 1'b0, 1'b0, '0, 1'($urandom_range(0, 1)), rnd[VAW-1:0],
                    1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
